// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_pkg: shared encodings and helpers for the data-memory access
// sequencer (mem_access_ctrl).
//   - SZ_* : request size encodings (byte/half/word, 11 reserved)
//   - state_e : controller FSM states
//   - is_aligned / byte_en / store_rep : address check, lane enables and
//     store-data replication for a size/address-offset pair
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Size 11 falls to the default and is always rejected.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating across all lanes lets the byte enables alone pick the target.
  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: core load/store request/response signals plus the
// handshaked data-memory bus.
//   modport slave  : the access controller
//   modport master : the environment (core stage + data memory)
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsign, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output stall, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsign, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  stall, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_align_ext.sv
// load_align_ext: picks the addressed byte/halfword lane out of a memory
// read word and sign- or zero-extends it to 32 bits. Words pass unchanged.
//   rdata   : raw memory word
//   addr_lo : request address bits [1:0]
//   size    : SZ_BYTE / SZ_HALF / SZ_WORD
//   unsign  : 1 = zero-extend, 0 = sign-extend
//   data    : aligned, extended result
module load_align_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsign,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (size)
      SZ_BYTE: data = unsign ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: data = unsign ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store sequencer between the core's
// load/store stage and a handshaked data memory. One request at a time;
// the core is stalled while it is in flight.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : mem_access_ctrl_if.slave (core request/response + memory bus)
// Optional build macro MEM_TIMEOUT_EN: abort an access with a bus error
// after TIMEOUT_CYC ACCESS cycles without mem_ack.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        unsign_q, unsign_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  load_align_ext u_ext (
    .rdata   (bus.mem_rdata),
    .addr_lo (lane_q),
    .size    (size_q),
    .unsign  (unsign_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      lane_q   <= '0;
      unsign_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      unsign_q <= unsign_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    lane_d   = lane_q;
    unsign_d = unsign_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_aligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d  = ACCESS;
            we_d     = bus.req_we;
            addr_d   = {bus.req_addr[31:2], 2'b00};
            be_d     = byte_en(bus.req_size, bus.req_addr[1:0]);
            wdata_d  = store_rep(bus.req_size, bus.req_wdata);
            size_d   = bus.req_size;
            lane_d   = bus.req_addr[1:0];
            unsign_d = bus.req_unsign;
            err_d    = 1'b0;
            rdata_d  = '0;
`ifdef MEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            // Misaligned: answer with an error without touching memory.
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // An ack always wins, even on the cycle the timeout would fire.
        if (bus.mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ext_data;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall      = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    case (state_q)
      IDLE:   bus.stall = bus.req_valid;
      ACCESS: begin
        bus.stall   = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = we_q;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC  = 4;
  localparam int ACK_DLY = 3;
`else
  localparam int TO_CYC  = 255;
  localparam int ACK_DLY = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_unsign = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus.stall, bus.resp_valid, bus.resp_err, bus.mem_req, bus.mem_we} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {bus.stall, bus.resp_valid, bus.resp_err, bus.mem_req, bus.mem_we}); else n_pass++;
    n_chk++; if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 100'h0)
      $display("FAIL reset_data: rdata %h addr %h wdata %h be %b want all 0", bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be); else n_pass++;
    rst = 1'b0;
  endtask

  // One aligned access with the ack in the first ACCESS cycle.
  task automatic test_access(input string name, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsign = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    n_chk++; if ({bus.stall, bus.mem_req} !== 2'b10)
      $display("FAIL %s idle stall/req: got %b want 10", name, {bus.stall, bus.mem_req}); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if ({bus.stall, bus.mem_req, bus.mem_we, bus.resp_valid} !== {2'b11, we, 1'b0})
      $display("FAIL %s access ctrl: got %b want %b", name, {bus.stall, bus.mem_req, bus.mem_we, bus.resp_valid}, {2'b11, we, 1'b0}); else n_pass++;
    n_chk++; if (bus.mem_addr !== {addr[31:2], 2'b00})
      $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, {addr[31:2], 2'b00}); else n_pass++;
    n_chk++; if (bus.mem_be !== exp_be)
      $display("FAIL %s mem_be: got %b want %b", name, bus.mem_be, exp_be); else n_pass++;
    n_chk++; if (bus.mem_wdata !== exp_wdata)
      $display("FAIL %s mem_wdata: got %h want %h", name, bus.mem_wdata, exp_wdata); else n_pass++;
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if ({bus.resp_valid, bus.resp_err, bus.stall, bus.mem_req} !== 4'b1000)
      $display("FAIL %s resp ctrl: got %b want 1000", name, {bus.resp_valid, bus.resp_err, bus.stall, bus.mem_req}); else n_pass++;
    n_chk++; if (bus.resp_rdata !== exp_rdata)
      $display("FAIL %s resp_rdata: got %h want %h", name, bus.resp_rdata, exp_rdata); else n_pass++;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if ({bus.resp_valid, bus.stall} !== 2'b00)
      $display("FAIL %s after resp: got %b want 00", name, {bus.resp_valid, bus.stall}); else n_pass++;
  endtask

  task automatic test_loads();
    test_access("ld_b_s",  1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    test_access("ld_h_u",  1'b0, SZ_HALF, 1'b1, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 4'b1100, 32'h0, 32'h0000_BEEF);
    test_access("ld_h_s",  1'b0, SZ_HALF, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_8001, 4'b0011, 32'h0, 32'hFFFF_8001);
    test_access("ld_b_u",  1'b0, SZ_BYTE, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_F000, 4'b0010, 32'h0, 32'h0000_00F0);
    test_access("ld_w",    1'b0, SZ_WORD, 1'b1, 32'h0000_0600, 32'h0, 32'h8765_4321, 4'b1111, 32'h0, 32'h8765_4321);
  endtask

  task automatic test_stores();
    test_access("st_b",    1'b1, SZ_BYTE, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'hDEAD_BEEF, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    test_access("st_h",    1'b1, SZ_HALF, 1'b0, 32'h0000_0002, 32'hCAFE_BABE, 32'hDEAD_BEEF, 4'b1100, 32'hBABE_BABE, 32'h0);
    test_access("st_w",    1'b1, SZ_WORD, 1'b0, 32'h0000_0404, 32'h1234_5678, 32'h0,         4'b1111, 32'h1234_5678, 32'h0);
  endtask

  task automatic test_misaligned(input string name, input logic [1:0] size, input logic [31:0] addr);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = size; bus.req_addr = addr;
    @(negedge clk);
    n_chk++; if ({bus.stall, bus.mem_req} !== 2'b10)
      $display("FAIL %s idle: got %b want 10", name, {bus.stall, bus.mem_req}); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if ({bus.resp_valid, bus.resp_err, bus.mem_req, bus.stall} !== 4'b1100)
      $display("FAIL %s resp: got %b want 1100", name, {bus.resp_valid, bus.resp_err, bus.mem_req, bus.stall}); else n_pass++;
    n_chk++; if (bus.resp_rdata !== 32'h0)
      $display("FAIL %s rdata: got %h want 0", name, bus.resp_rdata); else n_pass++;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ack_outside_access();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({bus.mem_req, bus.resp_valid, bus.stall} !== 3'b000)
        $display("FAIL stray_ack cyc%0d: got %b want 000", i, {bus.mem_req, bus.resp_valid, bus.stall}); else n_pass++;
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic test_delayed_ack();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_HALF;
    bus.req_addr = 32'h0000_0502; bus.req_wdata = 32'h0000_7E57;
    @(posedge clk); #1;
    for (int i = 0; i < ACK_DLY; i++) begin
      @(negedge clk);
      n_chk++; if ({bus.mem_req, bus.mem_we, bus.stall, bus.resp_valid} !== 4'b1110)
        $display("FAIL wait ctrl cyc%0d: got %b want 1110", i, {bus.mem_req, bus.mem_we, bus.stall, bus.resp_valid}); else n_pass++;
      n_chk++; if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {32'h0000_0500, 4'b1100, 32'h7E57_7E57})
        $display("FAIL wait bus cyc%0d: addr %h be %b wdata %h want 00000500 1100 7e577e57", i, bus.mem_addr, bus.mem_be, bus.mem_wdata); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++; if (bus.mem_req !== 1'b1)
      $display("FAIL wait last req: got %b want 1", bus.mem_req); else n_pass++;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.resp_valid, bus.resp_err, bus.mem_req} !== 3'b100)
      $display("FAIL wait resp: got %b want 100", {bus.resp_valid, bus.resp_err, bus.mem_req}); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b0)
      $display("FAIL wait single pulse: got %b want 0", bus.resp_valid); else n_pass++;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_addr = 32'h0000_0800;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.mem_req !== 1'b1)
      $display("FAIL rst_mid pre req: got %b want 1", bus.mem_req); else n_pass++;
    @(posedge clk); #2;
    rst = 1'b1; bus.req_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #1;
    n_chk++; if ({bus.mem_req, bus.stall, bus.resp_valid} !== 3'b000)
      $display("FAIL rst_mid async: got %b want 000", {bus.mem_req, bus.stall, bus.resp_valid}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if ({bus.resp_valid, bus.mem_req} !== 2'b00)
        $display("FAIL rst_mid after cyc%0d: got %b want 00", i, {bus.resp_valid, bus.mem_req}); else n_pass++;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_addr = 32'h0000_0700;
    bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    for (int i = 0; i < TO_CYC; i++) begin
      @(negedge clk);
      n_chk++; if (bus.mem_req !== 1'b1)
        $display("FAIL timeout req cyc%0d: got %b want 1", i, bus.mem_req); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++; if ({bus.mem_req, bus.resp_valid, bus.resp_err} !== 3'b011)
      $display("FAIL timeout resp: got %b want 011", {bus.mem_req, bus.resp_valid, bus.resp_err}); else n_pass++;
    n_chk++; if (bus.resp_rdata !== 32'h0)
      $display("FAIL timeout rdata: got %h want 0", bus.resp_rdata); else n_pass++;
    bus.req_valid = 1'b0; bus.mem_rdata = 32'h0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned("mis_w", SZ_WORD, 32'h0000_0402);
    test_misaligned("mis_h", SZ_HALF, 32'h0000_0203);
    test_misaligned("mis_r", 2'b11,   32'h0000_0100);
    test_ack_outside_access();
    test_delayed_ack();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
